// File: rtl/rgb_rainbow_sequencer_pkg.sv
// rgb_rainbow_sequencer_pkg: phase encodings, channel indices and the phase-to-channel table
package rgb_rainbow_sequencer_pkg;
   localparam logic [2:0] PH_R = 3'd0, PH_RG = 3'd1, PH_G = 3'd2, PH_GB = 3'd3, PH_B = 3'd4, PH_BR = 3'd5;
   localparam int NUM_PHASES = 6;
   localparam int CH_R = 0, CH_G = 1, CH_B = 2;
   typedef struct packed {
      logic [2:0] mask;
      logic [1:0] lead;
   } phase_cfg_t;
   function automatic phase_cfg_t phase_cfg(input logic [2:0] ph);
      case (ph)
         PH_R:    return '{mask: 3'b001, lead: 2'(CH_R)};
         PH_RG:   return '{mask: 3'b011, lead: 2'(CH_R)};
         PH_G:    return '{mask: 3'b010, lead: 2'(CH_G)};
         PH_GB:   return '{mask: 3'b110, lead: 2'(CH_G)};
         PH_B:    return '{mask: 3'b100, lead: 2'(CH_B)};
         PH_BR:   return '{mask: 3'b101, lead: 2'(CH_B)};
         default: return '{mask: 3'b000, lead: 2'(CH_R)};
      endcase
   endfunction
endpackage

// File: rtl/rgb_rainbow_sequencer_if.sv
// rgb_rainbow_sequencer_if: generator-facing and LED-facing signals of the rainbow sequencer
interface rgb_rainbow_sequencer_if;
   logic       ENABLE;
   logic [2:0] STT;
   logic [2:0] PWM_IN;
   logic [2:0] FLAG;
   logic [2:0] LED;
   logic [2:0] PHASE;
   logic       PHASE_STB;
   modport master (output ENABLE, STT, PWM_IN, input FLAG, LED, PHASE, PHASE_STB);
   modport slave (input ENABLE, STT, PWM_IN, output FLAG, LED, PHASE, PHASE_STB);
endinterface

// File: rtl/rgb_rainbow_sequencer_stt_edge_detect.sv
// rgb_rainbow_sequencer_stt_edge_detect: STT history with reset-to-ones so a level held through reset is not an edge
module rgb_rainbow_sequencer_stt_edge_detect (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] stt_i,
   output logic [2:0] rise_o
);
   logic [2:0] stt_q;
   always_ff @(posedge clk) stt_q <= rst ? 3'b111 : stt_i;
   assign rise_o = stt_i & ~stt_q;
endmodule

// File: rtl/rgb_rainbow_sequencer.sv
// rgb_rainbow_sequencer: steps a 6-phase rainbow on lead-channel ramp ends and gates PWM onto the LEDs
module rgb_rainbow_sequencer
   import rgb_rainbow_sequencer_pkg::*;
#(
   parameter int   RAMPS_PER_PHASE = 2,
   parameter logic OFF_LEVEL       = 1'b1,
   parameter int   CNT_W           = 8
) (
   input logic                   CLK,
   input logic                   RST,
   rgb_rainbow_sequencer_if.slave bus
);
   logic [2:0]       rise, phase_q, phase_d, flag_q, flag_d, led_q, led_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             stb_q, stb_d, bad, hit, adv;
   phase_cfg_t       cfg, cfg_d;
   rgb_rainbow_sequencer_stt_edge_detect u_edge (
      .clk   (CLK),
      .rst   (RST),
      .stt_i (bus.STT),
      .rise_o(rise)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         phase_q <= PH_R;
         count_q <= '0;
         stb_q   <= 1'b0;
         flag_q  <= 3'b000;
         led_q   <= {3{OFF_LEVEL}};
      end else begin
         phase_q <= phase_d;
         count_q <= count_d;
         stb_q   <= stb_d;
         flag_q  <= flag_d;
         led_q   <= led_d;
      end
   end
   // Encodings 6/7 fall back to phase 0 without a strobe.
   always_comb begin
      cfg     = phase_cfg(phase_q);
      bad     = phase_q >= 3'(NUM_PHASES);
      hit     = bus.ENABLE & rise[cfg.lead];
      adv     = hit & (count_q == CNT_W'(RAMPS_PER_PHASE - 1));
      phase_d = bad ? PH_R : adv ? (phase_q == PH_BR ? PH_R : phase_q + 3'd1) : phase_q;
      count_d = (bad | adv) ? '0 : hit ? count_q + CNT_W'(1) : count_q;
      stb_d   = adv & ~bad;
   end
   always_comb begin
      cfg_d  = phase_cfg(phase_d);
      flag_d = ~cfg_d.mask;
      led_d  = bus.ENABLE ? ((bus.PWM_IN & cfg.mask) | ({3{OFF_LEVEL}} & ~cfg.mask)) : {3{OFF_LEVEL}};
   end
   assign bus.PHASE     = phase_q;
   assign bus.PHASE_STB = stb_q;
   assign bus.FLAG      = flag_q;
   assign bus.LED       = led_q;
endmodule

// File: doc/rgb_rainbow_sequencer.md
Name: rgb_rainbow_sequencer

Overview:
- Colour-sequencing stage that wraps the three per-channel breathing PWM generators: one generator each for the R, G and B channels.
- Upstream, it drives each generator's ramp-direction FLAG.
- Downstream, it consumes each generator's STT end-of-ramp indication and raw PWM output.
- It steps through a 6-phase rainbow (R, RG, G, GB, B, BR) and gates the raw PWM onto the LED pins, so only the phase's channels light.

Parameters:
- RAMPS_PER_PHASE, 2: number of lead-channel end-of-ramp events counted before advancing phase; legal range 1..255.
- OFF_LEVEL, 1'b1: LED pin level driven for a disabled channel. Matches the generator's PWM idle-high sense.
- CNT_W, 8: width of the ramp counter; must hold RAMPS_PER_PHASE.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- ENABLE  in  1  run/pause. Low freezes sequencing and blanks the LEDs.
- STT  in  3  end-of-ramp level from the generators; bit0=R, bit1=G, bit2=B. May stay high for many cycles.
- PWM_IN  in  3  raw PWM from the generators; same bit order.
- FLAG  out  3  ramp direction to the generators; same bit order.
- LED  out  3  gated LED drive; same bit order.
- PHASE  out  3  current phase, 0..5.
- PHASE_STB  out  1  one-cycle pulse on each phase advance.

Behaviour:
- Reset (RST high at a CLK edge) sets:
  - PHASE=0
  - ramp count=0
  - FLAG=3'b000
  - PHASE_STB=0
  - LED=all OFF_LEVEL
  - STT history register=3'b111, so an STT already high at reset release is not taken as a rising edge.
- Phase table, listed as phase: active mask {B,G,R}, lead channel:
  - 0: 001, R
  - 1: 011, R
  - 2: 010, G
  - 3: 110, G
  - 4: 100, B
  - 5: 101, B
- Edge detect: rise[i] = STT[i] & ~stt_q[i]. stt_q is registered every cycle, including when ENABLE is low.
- Only rise[lead] is acted on; rises on other channels are ignored.
- FSM per cycle, when ENABLE=1 and rise[lead]=1:
  - If count == RAMPS_PER_PHASE-1: count becomes 0, PHASE becomes (PHASE==5 ? 0 : PHASE+1), PHASE_STB=1 for exactly that next cycle.
  - Otherwise: count increments.
- Advance latency: PHASE and PHASE_STB change on the CLK edge following the cycle in which rise[lead] is seen. This is one registered stage after stt_q.
- FLAG, registered from the phase: active channels 0 (decrementing ramp, smooth fade); inactive channels 1. FLAG updates together with PHASE.
- LED, registered, 1-cycle latency from PWM_IN:
  - ENABLE=1: LED[i] = mask[i] ? PWM_IN[i] : OFF_LEVEL, using the mask of the current PHASE.
  - ENABLE=0: LED = all OFF_LEVEL.
- ENABLE low: PHASE, count and FLAG hold. A lead rise occurring while ENABLE=0 is discarded, not deferred. Resuming waits for the next rising edge.
- Wrap: phase 5 advances to 0, and count restarts at 0 on every advance.
- RAMPS_PER_PHASE=1: every lead rise advances the phase.
- Reset mid-phase or while PHASE_STB is high: the synchronous reset wins and every state element goes to its reset value on that edge.
- Unreachable PHASE encodings 6 and 7 recover to 0 on the next cycle, with no PHASE_STB.

Decomposition:
- Shared package:
  - phase encoding constants PH_R..PH_BR (0..5)
  - NUM_PHASES=6
  - channel index constants CH_R=0, CH_G=1, CH_B=2
  - a function mapping phase to {mask, lead index}
- Sub-module: stt_edge_detect. It holds the 3-bit STT history register and produces the rise vector, with reset-to-ones.

Test Plan:
1. Reset with STT=3'b111 held high, release RST, hold STT high 50 cycles -> no advance, PHASE=0, count=0, PHASE_STB never asserted.
2. RAMPS_PER_PHASE=2, ENABLE=1, pulse STT[0] (low 10 / high 10) twice -> PHASE 0->1 exactly one cycle after the 2nd rise registers. PHASE_STB high 1 cycle. FLAG goes 3'b110 -> 3'b100.
3. Drive 12 lead-channel rises across all phases, always toggling the current lead -> PHASE sequence 0,1,2,3,4,5,0. Exactly 6 PHASE_STB pulses. Rises on non-lead channels are injected and cause no change.
4. PHASE=1, PWM_IN toggling on all bits -> LED[0], LED[1] follow PWM_IN with 1-cycle delay. LED[2] is constant 1.
5. Lower ENABLE, deliver lead rises, then raise ENABLE -> LED all 1 while paused. PHASE/count unchanged. After ENABLE returns, the next 2 rises are needed to advance.
6. Assert RST in the same cycle a terminal lead rise arrives in phase 5 -> PHASE=0, count=0, PHASE_STB=0, LED=3'b111 on the next cycle.
